// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, combinational imem address, IF/ID register toward decode.
// Latency: first word valid one edge after reset release or redirect; one word per cycle when decode is ready.
// Backpressure: decode_ready low holds pc and if_id; optional halt on EBREAK/zero word when FETCH_HALT_EN is defined.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    PC_WIDTH   = 64,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    input  logic [31:0]           instruction_data,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_target,
    input  logic                  decode_ready,
    output logic                  if_id_valid,
    output logic [31:0]           if_id_instruction,
    output logic [PC_WIDTH-1:0]   if_id_pc,
    output logic                  halted
);

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    logic [PC_WIDTH-1:0] pc;
    logic                advance;
    logic                halt_word;
    logic                unused_target_bits;

    // Byte offset bits of the redirect target are discarded.
    assign unused_target_bits  = ^redirect_target[1:0];
    assign instruction_address = pc[ADDR_WIDTH+1:2];
    assign advance             = !halted && (!if_id_valid || decode_ready);

`ifdef FETCH_HALT_EN
    logic halted_q;

    assign halt_word = (instruction_data == 32'h00100073) || (instruction_data == 32'h00000000);
    assign halted    = halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else if (advance && halt_word) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign halt_word = 1'b0;
    assign halted    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc                <= RESET_PC;
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_WORD;
            if_id_pc          <= '0;
        end else if (redirect_valid) begin
            pc          <= {redirect_target[PC_WIDTH-1:2], 2'b00};
            if_id_valid <= 1'b0;
        end else if (advance) begin
            if_id_instruction <= instruction_data;
            if_id_pc          <= pc;
            if_id_valid       <= 1'b1;
            // A halting word is kept on if_id but the pc parks on it.
            if (!halt_word) begin
                pc <= pc + PC_WIDTH'(4);
            end
        end else if (if_id_valid && decode_ready) begin
            // Only reachable while halted: drain the last word, fetch nothing new.
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a cycle-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  instruction_address;
    logic [31:0] instruction_data;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        decode_ready;
    logic        if_id_valid;
    logic [31:0] if_id_instruction;
    logic [63:0] if_id_pc;
    logic        halted;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    assign instruction_data = mem[instruction_address];

    fetch_unit dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .instruction_address (instruction_address),
        .instruction_data    (instruction_data),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .decode_ready        (decode_ready),
        .if_id_valid         (if_id_valid),
        .if_id_instruction   (if_id_instruction),
        .if_id_pc            (if_id_pc),
        .halted              (halted)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: next fetch pc, the word held for decode, halt flag.
    logic [63:0] m_pc;
    logic        m_vld;
    logic [31:0] m_ins;
    logic [63:0] m_ipc;
    logic        m_halt;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 64'h0;
        m_vld  = 1'b0;
        m_ins  = 32'h00000013;
        m_ipc  = 64'h0;
        m_halt = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},   64'(instruction_address), 64'(m_pc[9:2]));
        chk({tag, ".valid"},  64'(if_id_valid),         64'(m_vld));
        chk({tag, ".instr"},  64'(if_id_instruction),   64'(m_ins));
        chk({tag, ".pc"},     if_id_pc,                 m_ipc);
        chk({tag, ".halted"}, 64'(halted),              64'(m_halt));
    endtask

    // Apply one rising edge to the model using the inputs currently driven, then check at the falling edge.
    task automatic step(input string tag);
        logic [63:0] n_pc;
        logic        n_vld;
        logic [31:0] n_ins;
        logic [63:0] n_ipc;
        logic        n_halt;
        logic [31:0] word;
        n_pc = m_pc; n_vld = m_vld; n_ins = m_ins; n_ipc = m_ipc; n_halt = m_halt;
        word = mem[m_pc[9:2]];
        if (redirect_valid) begin
            n_pc   = redirect_target & ~64'h3;
            n_vld  = 1'b0;
            n_halt = 1'b0;
        end else if (!m_halt && (!m_vld || decode_ready)) begin
            n_ins = word;
            n_ipc = m_pc;
            n_vld = 1'b1;
            if (HALT_EN && (word == 32'h00100073 || word == 32'h0))
                n_halt = 1'b1;
            else
                n_pc = m_pc + 64'd4;
        end else if (m_vld && decode_ready) begin
            n_vld = 1'b0;
        end
        @(posedge clk);
        m_pc = n_pc; m_vld = n_vld; m_ins = n_ins; m_ipc = n_ipc; m_halt = n_halt;
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom & 32'hFFFF_FF80) | 32'h13;
        mem[0] = 32'h11111113;
        mem[1] = 32'h22222213;
        mem[2] = 32'h33333313;
        mem[3] = 32'h44444413;

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0; decode_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");

        // Sequential fetch from reset.
        rst_n = 1'b1;
        step("t1a");
        chk("t1_first_pc", if_id_pc, 64'h0);
        chk("t1_first_ins", 64'(if_id_instruction), 64'h11111113);
        step("t1b");
        chk("t1_second_ins", 64'(if_id_instruction), 64'h22222213);

        // Backpressure holds pc=4.
        decode_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("t2_stall");
        chk("t2_hold_pc", if_id_pc, 64'h4);
        chk("t2_hold_addr", 64'(instruction_address), 64'h2);
        decode_ready = 1'b1;
        step("t2_release");
        chk("t2_next_pc", if_id_pc, 64'h8);

        // Redirect during a stall; low target bits dropped.
        decode_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h22;
        step("t3_redir");
        chk("t3_flush", 64'(if_id_valid), 64'h0);
        redirect_valid = 1'b0; decode_ready = 1'b1;
        step("t3_target");
        chk("t3_pc", if_id_pc, 64'h20);
        chk("t3_ins", 64'(if_id_instruction), 64'(mem[8]));

        // Address alias past word 255.
        redirect_valid = 1'b1; redirect_target = 64'h3FC;
        step("t4_redir");
        redirect_valid = 1'b0;
        step("t4_w255");
        chk("t4_pc255", if_id_pc, 64'h3FC);
        step("t4_wrap");
        chk("t4_pc400", if_id_pc, 64'h400);
        chk("t4_ins_word0", 64'(if_id_instruction), 64'h11111113);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_valid", 64'(if_id_valid), 64'h0);
        chk("t5_ins", 64'(if_id_instruction), 64'h13);
        chk("t5_addr", 64'(instruction_address), 64'h0);
        @(negedge clk);
        check_all("t5_held");
        rst_n = 1'b1;
        step("t5_restart");

`ifdef FETCH_HALT_EN
        mem[2] = 32'h00100073;
        redirect_valid = 1'b1; redirect_target = 64'h0; decode_ready = 1'b1;
        step("t6_redir");
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) step("t6_run");
        chk("t6_halt_pc", if_id_pc, 64'h8);
        chk("t6_halted", 64'(halted), 64'h1);
        chk("t6_addr", 64'(instruction_address), 64'h2);
        step("t6_drain");
        chk("t6_drained", 64'(if_id_valid), 64'h0);
        step("t6_idle");
        redirect_valid = 1'b1; redirect_target = 64'h0;
        step("t6_clear");
        chk("t6_unhalt", 64'(halted), 64'h0);
        redirect_valid = 1'b0;
        step("t6_resume");
        chk("t6_resume_ins", 64'(if_id_instruction), 64'h11111113);
        mem[2] = 32'h33333313;
`endif

        // Random traffic, with a few halting opcodes planted in memory.
        mem[17]  = 32'h00100073;
        mem[200] = 32'h00000000;
        for (int i = 0; i < 400; i++) begin
            decode_ready   = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_target = (i % 3 == 0) ? 64'($urandom_range(0, 1023))
                                           : {$urandom, $urandom};
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
